xdma_cfg_frame_assembler: RTL
=============================

XDMA_CFG_FRAME_ASSEMBLER -- requirements
Module: xdma_cfg_frame_assembler

Interface
REQ-001 SHALL have parameter DataWidth, default 512: frame width in bits.
REQ-002 SHALL have parameter AddrWidth, default 48: reader/writer address width.
REQ-003 SHALL have parameter IdWidth, default 4: DMA id width.
REQ-004 SHALL have parameter FrameLenWidth, default 4: frame_length field width.
REQ-005 SHALL have parameter MaxFrames, default 4: largest accepted frame_length. Legal range 1..2^FrameLenWidth-1. DataWidth SHALL be >= 1+FrameLenWidth+IdWidth+2*AddrWidth.
REQ-006 SHALL have port clk_i, input, 1: single clock.
REQ-007 SHALL have port rst_i, input, 1: reset, asynchronous, active-high.
REQ-008 SHALL have port frame_valid_i, input, 1: incoming frame valid.
REQ-009 SHALL have port frame_ready_o, output, 1: frame accepted when valid&ready.
REQ-010 SHALL have port frame_data_i, input, DataWidth: frame; [0]=dma_type, [FrameLenWidth:1]=frame_length in every frame; first frame additionally carries dma_id, reader_addr and writer_addr in the next bits upward, in that order.
REQ-011 SHALL have port cfg_valid_o, output, 1: assembled config valid.
REQ-012 SHALL have port cfg_ready_i, input, 1: consumer ready.
REQ-013 SHALL have port cfg_dma_type_o, output, 1: dma_type (0 read, 1 write).
REQ-014 SHALL have port cfg_dma_id_o, output, IdWidth: dma_id.
REQ-015 SHALL have ports cfg_reader_addr_o and cfg_writer_addr_o, output, AddrWidth each: addresses from the first frame.
REQ-016 SHALL have port cfg_frame_length_o, output, FrameLenWidth: frame count.
REQ-017 SHALL have port cfg_payload_o, output, MaxFrames*DataWidth: raw frames; frame k at [k*DataWidth +: DataWidth].
REQ-018 SHALL have port err_o, output, 1: single-cycle error pulse.
REQ-019 SHALL have port err_code_o, output, 2: 01 = bad length, 10 = header mismatch, 00 otherwise; nonzero only while err_o is high.
REQ-020 SHALL have port busy_o, output, 1: high when state is not IDLE.

Function
REQ-021 SHALL implement the states IDLE, COLLECT and OUTPUT, plus a frame counter cnt_q of width $clog2(MaxFrames+1).
REQ-022 frame_ready_o SHALL be 1 in IDLE and COLLECT and 0 in OUTPUT, driven from state only, with no combinational path from frame_valid_i.
REQ-023 IDLE, accepted frame with length L in 1..MaxFrames:
- Clear the whole payload buffer to zero.
- Store the frame at slot 0.
- Latch the header fields and set cnt_q=1.
- Go to OUTPUT if L==1, else to COLLECT.
REQ-024 IDLE, accepted frame with L==0 or L>MaxFrames:
- Drop the frame.
- Pulse err_o with err_code_o=01 in the following cycle.
- Stay in IDLE.
REQ-025 COLLECT, accepted frame whose dma_type and frame_length equal the latched values:
- Store the frame at slot cnt_q and increment cnt_q.
- When cnt_q+1==L, go to OUTPUT.
REQ-026 COLLECT, accepted frame whose header mismatches:
- Drop the frame and discard the partial config.
- Pulse err_o with err_code_o=10 in the following cycle.
- Go to IDLE. The mismatching frame SHALL NOT be reinterpreted as a new first frame.
REQ-027 cfg_valid_o SHALL assert in the cycle after the last frame handshake and SHALL hold all cfg_* outputs stable until cfg_valid_o&cfg_ready_i. On that handshake the block SHALL go to IDLE and accept frames from the next cycle.
REQ-028 Payload slots at index >= L SHALL read zero while cfg_valid_o is high.
REQ-029 frame_valid_i SHALL be ignored in OUTPUT. Back-to-back frames with no gaps SHALL be accepted in IDLE and COLLECT.
REQ-030 cfg_* outputs SHALL be driven directly from registers.

Reset
REQ-031 Asserting rst_i in any state, including mid-COLLECT or while cfg_valid_o is high, SHALL immediately force IDLE and clear cnt_q, the buffer and the latched header.
REQ-032 While rst_i is asserted, all outputs SHALL be 0 except frame_ready_o, which SHALL be 1 (IDLE). After release, the first frame handshake SHALL be treated as a first frame.

Verification
REQ-033 The bench SHALL cover the single-frame case:
- Stimulus: one frame, type=1, L=1, id=3, reader=0x1000, writer=0x2000.
- Response: cfg_valid_o high 1 cycle later with those values; payload slots 1..3 zero.
REQ-034 The bench SHALL cover a multi-frame config under backpressure:
- Stimulus: L=4 with 4 frames back-to-back; cfg_ready_i held low for 5 cycles.
- Response: cfg_valid_o rises the cycle after frame 4 and stays stable; frame_ready_o=0 until the handshake.
REQ-035 The bench SHALL cover bad lengths:
- Stimulus: first frame with L=0, then one with L=5 (MaxFrames=4).
- Response: two err_o pulses with code 01; cfg_valid_o never asserts.
REQ-036 The bench SHALL cover a header mismatch:
- Stimulus: L=3, then frame 2 carries L=2.
- Response: err_o with code 10; back in IDLE; the next valid L=1 frame produces cfg_valid_o.
REQ-037 The bench SHALL cover reset mid-operation:
- Stimulus: rst_i asserted after frame 2 of an L=4 config.
- Response: busy_o=0 immediately; a fresh L=2 sequence assembles correctly with slots 2..3 zero.
REQ-038 The bench SHALL cover the consumer boundary:
- Stimulus: cfg_ready_i=1 and a new first frame presented in the same cycle cfg_valid_o is high.
- Response: the frame is not accepted in that cycle; it is accepted the next cycle.

Source files
------------

// File: rtl/xdma_cfg_frame_assembler.sv
// xdma_cfg_frame_assembler
// Collects 1..MaxFrames consecutive frames into one DMA configuration.
// The first frame carries the header (type, length, id, reader/writer
// addresses); later frames must repeat type and length. The assembled
// config is held on registered outputs until the consumer takes it.
module xdma_cfg_frame_assembler #(
  parameter int unsigned DataWidth     = 512,
  parameter int unsigned AddrWidth     = 48,
  parameter int unsigned IdWidth       = 4,
  parameter int unsigned FrameLenWidth = 4,
  parameter int unsigned MaxFrames     = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           frame_valid_i,
  output logic                           frame_ready_o,
  input  logic [DataWidth-1:0]           frame_data_i,
  output logic                           cfg_valid_o,
  input  logic                           cfg_ready_i,
  output logic                           cfg_dma_type_o,
  output logic [IdWidth-1:0]             cfg_dma_id_o,
  output logic [AddrWidth-1:0]           cfg_reader_addr_o,
  output logic [AddrWidth-1:0]           cfg_writer_addr_o,
  output logic [FrameLenWidth-1:0]       cfg_frame_length_o,
  output logic [MaxFrames*DataWidth-1:0] cfg_payload_o,
  output logic                           err_o,
  output logic [1:0]                     err_code_o,
  output logic                           busy_o
);

  localparam int unsigned CntW  = $clog2(MaxFrames + 1);
  localparam int unsigned IdLsb = FrameLenWidth + 1;
  localparam int unsigned RdLsb = IdLsb + IdWidth;
  localparam int unsigned WrLsb = RdLsb + AddrWidth;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_OUTPUT
  } state_t;

  state_t                       r_state;
  state_t                       w_next;

  logic [CntW-1:0]              r_cnt;
  logic                         r_type;
  logic [FrameLenWidth-1:0]     r_len;
  logic [IdWidth-1:0]           r_id;
  logic [AddrWidth-1:0]         r_rd;
  logic [AddrWidth-1:0]         r_wr;
  logic [MaxFrames*DataWidth-1:0] r_payload;
  logic                         r_cfg_valid;
  logic                         r_err;
  logic [1:0]                   r_err_code;

  logic                         w_ready;
  logic                         w_busy;
  logic                         w_acc;
  logic                         w_f_type;
  logic [FrameLenWidth-1:0]     w_f_len;
  logic                         w_len_ok;
  logic                         w_hdr_match;
  logic                         w_last;

  assign w_f_type    = frame_data_i[0];
  assign w_f_len     = frame_data_i[FrameLenWidth:1];
  assign w_acc       = frame_valid_i & w_ready;
  assign w_len_ok    = (w_f_len != '0) && (w_f_len <= FrameLenWidth'(MaxFrames));
  assign w_hdr_match = (w_f_type == r_type) && (w_f_len == r_len);
  assign w_last      = ((FrameLenWidth'(r_cnt) + FrameLenWidth'(1)) == r_len);

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_acc && w_len_ok)
          w_next = (w_f_len == FrameLenWidth'(1)) ? S_OUTPUT : S_COLLECT;
      end
      S_COLLECT: begin
        if (w_acc) begin
          if (!w_hdr_match) w_next = S_IDLE;
          else if (w_last)  w_next = S_OUTPUT;
        end
      end
      S_OUTPUT: begin
        if (cfg_ready_i) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State-derived outputs; ready depends on state only
  always_comb begin
    w_ready = 1'b1;
    w_busy  = 1'b0;
    case (r_state)
      S_IDLE:    begin w_ready = 1'b1; w_busy = 1'b0; end
      S_COLLECT: begin w_ready = 1'b1; w_busy = 1'b1; end
      S_OUTPUT:  begin w_ready = 1'b0; w_busy = 1'b1; end
      default:   begin w_ready = 1'b1; w_busy = 1'b0; end
    endcase
  end

  // Datapath: header latch, payload buffer, frame counter, error pulse
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt       <= '0;
      r_type      <= 1'b0;
      r_len       <= '0;
      r_id        <= '0;
      r_rd        <= '0;
      r_wr        <= '0;
      r_payload   <= '0;
      r_cfg_valid <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= '0;
    end else begin
      r_err       <= 1'b0;
      r_err_code  <= '0;
      r_cfg_valid <= (w_next == S_OUTPUT);
      case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            if (w_len_ok) begin
              // Whole-buffer clear with slot 0 overwritten: unused slots read zero
              r_payload                <= '0;
              r_payload[DataWidth-1:0] <= frame_data_i;
              r_type <= w_f_type;
              r_len  <= w_f_len;
              r_id   <= frame_data_i[IdLsb +: IdWidth];
              r_rd   <= frame_data_i[RdLsb +: AddrWidth];
              r_wr   <= frame_data_i[WrLsb +: AddrWidth];
              r_cnt  <= CntW'(1);
            end else begin
              r_err      <= 1'b1;
              r_err_code <= 2'b01;
            end
          end
        end
        S_COLLECT: begin
          if (w_acc) begin
            if (w_hdr_match) begin
              for (int unsigned k = 0; k < MaxFrames; k++) begin
                if (r_cnt == CntW'(k))
                  r_payload[k*DataWidth +: DataWidth] <= frame_data_i;
              end
              r_cnt <= r_cnt + CntW'(1);
            end else begin
              r_err      <= 1'b1;
              r_err_code <= 2'b10;
              r_cnt      <= '0;
              r_type     <= 1'b0;
              r_len      <= '0;
              r_id       <= '0;
              r_rd       <= '0;
              r_wr       <= '0;
              r_payload  <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign frame_ready_o      = w_ready;
  assign busy_o             = w_busy;
  assign cfg_valid_o        = r_cfg_valid;
  assign cfg_dma_type_o     = r_type;
  assign cfg_dma_id_o       = r_id;
  assign cfg_reader_addr_o  = r_rd;
  assign cfg_writer_addr_o  = r_wr;
  assign cfg_frame_length_o = r_len;
  assign cfg_payload_o      = r_payload;
  assign err_o              = r_err;
  assign err_code_o         = r_err_code;

endmodule
